// File: rtl/odo_encrypt_drain.sv
// Encrypter result drain: captures 640-bit blocks into a small FIFO, serializes
// them LSW-first over valid/ready, and grants feeder credits against capacity.
module odo_encrypt_drain #(
    parameter int unsigned BLOCK = 640,
    parameter int unsigned WORD  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [BLOCK-1:0] in,
    input  logic             write,
    output logic             credit_ok,
    output logic [WORD-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow
);

    localparam int unsigned NWORDS = BLOCK / WORD;
    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam int unsigned IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BLOCK-1:0]    mem_q [DEPTH];
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                last_q, last_d;
    logic                overflow_q, overflow_d;
    logic                credit_q, credit_d;
    logic                fire, at_last, pop, push;
    logic [BLOCK-1:0]    head;

    always_comb begin
        fire       = (state_q == SEND) && out_ready;
        at_last    = (idx_q == IW'(NWORDS - 1));
        pop        = fire && at_last;
        // A full FIFO still takes a block when the head leaves on the same edge.
        push       = write && ((count_q < CW'(DEPTH)) || pop);
        overflow_d = overflow_q || (write && !push);

        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        idx_d = idx_q;
        if (fire) begin
            idx_d = at_last ? '0 : idx_q + IW'(1);
        end
        last_d  = (idx_d == IW'(NWORDS - 1));
        state_d = (count_d != '0) ? SEND : IDLE;

        inflight_d = inflight_q;
        unique case ({issue, write})
            2'b10:   inflight_d = (inflight_q == CW'(DEPTH)) ? inflight_q : inflight_q + CW'(1);
            2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        credit_d = ({1'b0, count_d} + {1'b0, inflight_d}) < (CW + 1)'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
            credit_q   <= credit_d;
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_data = head[idx_q*WORD +: WORD];
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = last_q;
    assign overflow  = overflow_q;
    assign credit_ok = credit_q;

endmodule

// File: tb/tb_odo_encrypt_drain.sv
// Scoreboard bench for odo_encrypt_drain: directed blocks push expected words,
// a negedge monitor compares every presented word and pops on handshake.
module tb_odo_encrypt_drain;

    localparam int unsigned BLOCK  = 640;
    localparam int unsigned WORD   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NWORDS = BLOCK / WORD;

    typedef struct {
        logic [WORD-1:0] data;
        logic            last;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue = 1'b0;
    logic [BLOCK-1:0] in_bus = '0;
    logic             write = 1'b0;
    logic             credit_ok;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic             overflow;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    odo_encrypt_drain #(.BLOCK(BLOCK), .WORD(WORD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .issue     (issue),
        .in        (in_bus),
        .write     (write),
        .credit_ok (credit_ok),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every presented word must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h last=%b, scoreboard empty", out_data, out_last);
            end else begin
                if (out_data !== sb[0].data || out_last !== sb[0].last) begin
                    errors++;
                    $display("FAIL word: got data=%h last=%b, expected data=%h last=%b",
                             out_data, out_last, sb[0].data, sb[0].last);
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BLOCK-1:0] mk(input logic [WORD-1:0] base);
        logic [BLOCK-1:0] b;
        for (int i = 0; i < NWORDS; i++) b[i*WORD +: WORD] = base + WORD'(i);
        return b;
    endfunction

    // Drives a block for the next edge and records its expected words.
    task automatic drive_write(input logic [WORD-1:0] base, input bit expect_kept);
        in_bus = mk(base);
        write  = 1'b1;
        if (expect_kept) begin
            for (int i = 0; i < NWORDS; i++) begin
                exp_t e;
                e.data = base + WORD'(i);
                e.last = (i == NWORDS - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        issue = 1'b0;
        write = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_credit", 64'(credit_ok), 64'd1);
        chk("rst_overflow", 64'(overflow), 64'd0);

        // Single block: issue, write ten cycles later, stream 20 words
        out_ready = 1'b1;
        issue = 1'b1;
        step();
        issue = 1'b0;
        chk("t1_credit_1inflight", 64'(credit_ok), 64'd1);
        for (int i = 0; i < 9; i++) step();
        drive_write(32'h0, 1'b1);
        step();
        write = 1'b0;
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_word0", 64'(out_data), 64'd0);
        wait_drain("t1_drain", 60);
        step();
        chk("t1_idle_after", 64'(out_valid), 64'd0);

        // Fill with ready low, fifth write overflows
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1;
            step();
        end
        issue = 1'b0;
        chk("t2_credit_inflight4", 64'(credit_ok), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            drive_write(32'h1000 * k, 1'b1);
            step();
        end
        write = 1'b0;
        chk("t2_credit_full", 64'(credit_ok), 64'd0);
        chk("t2_no_overflow", 64'(overflow), 64'd0);
        drive_write(32'hDEAD0000, 1'b0);
        step();
        write = 1'b0;
        chk("t2_overflow_set", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        wait_drain("t2_drain", 200);
        chk("t2_overflow_sticky", 64'(overflow), 64'd1);
        chk("t2_credit_free", 64'(credit_ok), 64'd1);

        // Full FIFO, write lands on the last-word pop edge
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive_write(32'h2000 * k, 1'b1);
            step();
        end
        write = 1'b0;
        chk("t3_credit_full", 64'(credit_ok), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < NWORDS - 1; i++) step();
        chk("t3_at_last", 64'(out_last), 64'd1);
        drive_write(32'h5A5A0000, 1'b1);
        step();
        write = 1'b0;
        chk("t3_no_overflow", 64'(overflow), 64'd0);
        chk("t3_still_full", 64'(credit_ok), 64'd0);
        chk("t3_no_gap", 64'(out_valid), 64'd1);
        wait_drain("t3_drain", 200);

        // Ready toggling: 40 cycles per block
        do_reset();
        drive_write(32'h7000, 1'b1);
        step();
        write = 1'b0;
        for (int i = 0; i < 2 * NWORDS; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end
        out_ready = 1'b0;
        chk("t4_all_words", 64'(sb.size()), 64'd0);
        chk("t4_idle", 64'(out_valid), 64'd0);

        // Simultaneous issue and write leave inflight unchanged
        do_reset();
        for (int i = 0; i < 2; i++) begin
            issue = 1'b1;
            step();
        end
        issue = 1'b0;
        chk("t5_credit_inflight2", 64'(credit_ok), 64'd1);
        issue = 1'b1;
        drive_write(32'h8000, 1'b1);
        step();
        issue = 1'b0;
        write = 1'b0;
        chk("t5_credit_c1_i2", 64'(credit_ok), 64'd1);
        issue = 1'b1;
        step();
        issue = 1'b0;
        chk("t5_credit_c1_i3", 64'(credit_ok), 64'd0);
        drive_write(32'h9000, 1'b1);
        step();
        write = 1'b0;
        chk("t5_credit_c2_i2", 64'(credit_ok), 64'd0);
        out_ready = 1'b1;
        wait_drain("t5_drain", 100);
        step();
        chk("t5_credit_c0_i2", 64'(credit_ok), 64'd1);

        // Reset mid-block with two blocks queued behind it
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue = 1'b1;
            step();
        end
        issue = 1'b0;
        out_ready = 1'b1;
        drive_write(32'hA000, 1'b1);
        step();
        drive_write(32'hB000, 1'b1);
        step();
        drive_write(32'hC000, 1'b1);
        step();
        write = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("t6_at_word7", 64'(out_data), 64'hA007);
        chk("t6_credit_before", 64'(credit_ok), 64'd0);
        reset = 1'b1;
        sb.delete();
        step();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_last", 64'(out_last), 64'd0);
        chk("t6_overflow", 64'(overflow), 64'd0);
        chk("t6_credit", 64'(credit_ok), 64'd1);
        reset = 1'b0;
        step();
        step();
        chk("t6_stay_idle", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
